// File: rtl/matrix_accumulate_array.sv
// Job-based multi-lane signed accumulator with optional saturation and a
// valid/ready result port; sits between the multiply array and write-back.
module matrix_accumulate_array #(
    parameter int LANES     = 4,
    parameter int IN_WIDTH  = 8,
    parameter int ACC_WIDTH = 16,
    parameter int K_WIDTH   = 10,
    parameter int SATURATE  = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         start,
    input  logic [K_WIDTH-1:0]           k_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*IN_WIDTH-1:0]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ACC_WIDTH-1:0]   out_data,
    output logic [LANES-1:0]             overflow,
    output logic                         busy
);

    // state    | meaning
    // st_idle  | waiting for start; result of last job still visible
    // st_accum | accepting beats until the remaining count hits terminal
    // st_hold  | result presented on out_data until out_ready
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [1:0]                          state;
    logic [K_WIDTH-1:0]                  remaining;
    logic [LANES-1:0][ACC_WIDTH-1:0]     acc;
    logic [LANES-1:0][ACC_WIDTH-1:0]     acc_next;
    logic [LANES-1:0]                    ovf;
    logic [LANES-1:0]                    lane_ovf;
    logic [LANES-1:0][IN_WIDTH-1:0]      in_lanes;

    assign in_lanes = in_data;

    // One guard bit above the accumulator: a sign mismatch between the top
    // two bits of the sum means the lane left the signed ACC_WIDTH range.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [ACC_WIDTH:0] sum;
        assign sum = {acc[i][ACC_WIDTH-1], acc[i]}
                   + {{(ACC_WIDTH+1-IN_WIDTH){in_lanes[i][IN_WIDTH-1]}}, in_lanes[i]};
        assign lane_ovf[i] = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        always_comb begin
            acc_next[i] = sum[ACC_WIDTH-1:0];
            if (lane_ovf[i] && (SATURATE != 0))
                acc_next[i] = sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            remaining <= '0;
            acc       <= '0;
            ovf       <= '0;
        end else if (clear) begin
            state     <= ST_IDLE;
            remaining <= '0;
            acc       <= '0;
            ovf       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= k_len;
                        acc       <= '0;
                        ovf       <= '0;
                        state     <= (k_len == '0) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc       <= acc_next;
                        ovf       <= ovf | lane_ovf;
                        remaining <= remaining - K_WIDTH'(1);
                        if (remaining == K_WIDTH'(1))
                            state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_ACCUM);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign out_data  = acc;
    assign overflow  = ovf;

endmodule
